// File: rtl/rsa_host_pkg.sv
// Shared types and constants for the exp2_rsa host-side bus driver.
package rsa_host_pkg;

  localparam int unsigned NBYTES = 32;

  localparam logic [1:0] RS_MSG = 2'b01;
  localparam logic [1:0] RS_EXP = 2'b10;
  localparam logic [1:0] RS_MOD = 2'b11;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_EMIT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/rsa_host_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the last allowed cycle.
module rsa_host_watchdog #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned TO_W    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/rsa_host_ctrl.sv
// Host-side driver for the exp2_rsa register bus: loads 96 operand bytes, starts the core,
// waits for completion and streams the 32 result bytes out with backpressure.
module rsa_host_ctrl
  import rsa_host_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned TO_W        = 20,
  parameter int unsigned TOTAL_CNT_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_timeout,
  output logic       core_we,
  output logic       core_oe,
  output logic       core_start,
  output logic [1:0] core_reg_sel,
  output logic [4:0] core_addr,
  output logic [7:0] core_data_w,
  input  logic [7:0] core_data_r,
  input  logic       core_ready
);

  localparam logic [TOTAL_CNT_W-1:0] LAST_C = TOTAL_CNT_W'(3 * NBYTES - 1);
  localparam logic [4:0]             LAST_K = 5'(NBYTES - 1);

  state_e                 state_q, state_d;
  logic [TOTAL_CNT_W-1:0] c_q, c_d;
  logic [4:0]             k_q, k_d;
  logic                   we_q, we_d;
  logic                   oe_q, oe_d;
  logic                   start_q, start_d;
  logic [1:0]             sel_q, sel_d;
  logic [4:0]             addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   err_q, err_d;
  logic                   wd_clear, wd_en, wd_expired;

  rsa_host_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Next state and next registered outputs; bus fields hold unless explicitly updated.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    k_d         = k_q;
    we_d        = 1'b0;
    start_d     = 1'b0;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          sel_d   = RS_MSG + c_q[TOTAL_CNT_W-1 -: 2];
          addr_d  = c_q[4:0];
          wdata_d = in_data;
          if (c_q == LAST_C) begin
            c_d     = '0;
            state_d = ST_START;
          end else begin
            c_d = c_q + TOTAL_CNT_W'(1);
          end
        end
      end
      ST_START: begin
        start_d  = 1'b1;
        wd_clear = 1'b1;
        state_d  = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else if (!core_ready) begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else if (core_ready) begin
          k_d     = '0;
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        out_data_d  = core_data_r;
        out_valid_d = 1'b1;
        state_d     = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == LAST_K) begin
            state_d = ST_RELEASE;
          end else begin
            k_d     = k_q + 5'd1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RELEASE: begin
        c_d     = '0;
        k_d     = '0;
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Read-side bus is decoded from the next state so it is valid throughout the state.
    if (state_d == ST_RD_ADDR) begin
      addr_d = k_d;
    end
    oe_d = (state_d == ST_RD_ADDR) || (state_d == ST_RD_CAP) || (state_d == ST_EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      c_q         <= '0;
      k_q         <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      start_q     <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      k_q         <= k_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      start_q     <= start_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_LOAD) || (c_q != '0);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign err_timeout  = err_q;
  assign core_we      = we_q;
  assign core_oe      = oe_q;
  assign core_start   = start_q;
  assign core_reg_sel = sel_q;
  assign core_addr    = addr_q;
  assign core_data_w  = wdata_q;

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Bench for rsa_host_ctrl with a behavioural exp2_rsa core model (64-bit arithmetic on operand low bytes).
module tb_rsa_host_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       err_timeout;
  logic       core_we;
  logic       core_oe;
  logic       core_start;
  logic [1:0] core_reg_sel;
  logic [4:0] core_addr;
  logic [7:0] core_data_w;
  logic [7:0] core_data_r;
  logic       core_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_host_ctrl #(
    .TIMEOUT     (100),
    .TO_W        (20),
    .TOTAL_CNT_W (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .core_we      (core_we),
    .core_oe      (core_oe),
    .core_start   (core_start),
    .core_reg_sel (core_reg_sel),
    .core_addr    (core_addr),
    .core_data_w  (core_data_w),
    .core_data_r  (core_data_r),
    .core_ready   (core_ready)
  );

  // ---------------- core model ----------------
  logic [255:0] m_r, e_r, n_r, res_r;
  logic         calc;
  int           ccnt;
  logic         hang;

  function automatic logic [63:0] modexp(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
    logic [127:0] r, b, nn;
    if (n == 64'd0) return 64'd0;
    nn = {64'd0, n};
    r  = 128'd1 % nn;
    b  = {64'd0, m} % nn;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[63:0];
  endfunction

  assign core_ready = !calc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r <= '0; e_r <= '0; n_r <= '0; res_r <= '0;
      calc <= 1'b0; ccnt <= 0; core_data_r <= '0;
    end else begin
      if (core_we && !calc) begin
        case (core_reg_sel)
          2'b01: m_r[{core_addr, 3'b000} +: 8] <= core_data_w;
          2'b10: e_r[{core_addr, 3'b000} +: 8] <= core_data_w;
          2'b11: n_r[{core_addr, 3'b000} +: 8] <= core_data_w;
          default: ;
        endcase
      end
      if (core_start && !calc) begin
        calc  <= 1'b1;
        ccnt  <= 20;
        res_r <= {192'd0, modexp(m_r[63:0], e_r[63:0], n_r[63:0])};
      end else if (calc && !hang) begin
        if (ccnt == 0) calc <= 1'b0;
        else ccnt <= ccnt - 1;
      end
      if (core_oe) core_data_r <= res_r[{core_addr, 3'b000} +: 8];
    end
  end

  // ---------------- bus monitor ----------------
  logic [1:0] wl_sel[$];
  logic [4:0] wl_addr[$];
  logic [7:0] wl_data[$];
  int start_cnt, start_we_bad, start_cyc, last_we_cyc, err_cnt;

  always @(negedge clk) begin
    if (core_we) begin
      wl_sel.push_back(core_reg_sel);
      wl_addr.push_back(core_addr);
      wl_data.push_back(core_data_w);
      last_we_cyc = cyc;
    end
    if (core_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (core_we) start_we_bad++;
    end
    if (err_timeout) err_cnt++;
  end

  // ---------------- helpers ----------------
  localparam logic [29:0] RST_EXP = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 8'h00};

  function automatic logic [29:0] outs();
    return {in_ready, out_valid, out_data, busy, err_timeout, core_we, core_oe, core_start,
            core_reg_sel, core_addr, core_data_w};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] job_b [96];

  task automatic fill_job(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
    for (int i = 0; i < 32; i++) begin
      job_b[i]      = (i < 8) ? m[i*8 +: 8] : 8'h00;
      job_b[32 + i] = (i < 8) ? e[i*8 +: 8] : 8'h00;
      job_b[64 + i] = (i < 8) ? n[i*8 +: 8] : 8'h00;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("send_in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input bit gaps);
    for (int i = 0; i < 96; i++) begin
      if (gaps && (i % 3 == 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(job_b[i]);
    end
  endtask

  // Collect n result bytes; optional stall at byte bp_idx, optional reset at byte rst_at.
  task automatic recv(input int n, input int bp_idx, input int rst_at,
                      output logic [255:0] res, output int got);
    int t;
    logic [7:0] held;
    got = 0; res = '0; t = 0;
    out_ready = 1'b1;
    while (got < n && t < 3000) begin
      if (out_valid) begin
        if (got == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          chk("reset_mid_read_outs", 64'(outs()), 64'(RST_EXP));
          reset = 1'b0;
          @(negedge clk);
          chk("after_reset_outs", 64'(outs()), 64'(RST_EXP));
          return;
        end
        if (got == bp_idx) begin
          held = out_data;
          out_ready = 1'b0;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data_stable", 64'(out_data), 64'(held));
            chk("bp_addr", 64'(core_addr), 64'(bp_idx));
            chk("bp_oe", 64'(core_oe), 64'd1);
            chk("bp_valid", 64'(out_valid), 64'd1);
          end
          out_ready = 1'b1;
        end
        res[got*8 +: 8] = out_data;
        got++;
      end
      @(negedge clk);
      t++;
    end
    if (got < n) chk("recv_timeout_bytes", 64'(got), 64'(n));
  endtask

  task automatic check_result(input string name, input logic [255:0] act, input logic [255:0] exp);
    for (int i = 0; i < 32; i++) chk(name, 64'(act[i*8 +: 8]), 64'(exp[i*8 +: 8]));
  endtask

  typedef struct {
    int         idx;
    logic [1:0] sel;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_vec_t;

  wr_vec_t wv [6];

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] res;
    int got, bad, t;

    wv = '{'{0,  2'b01, 5'd0,  8'd0},  '{31, 2'b01, 5'd31, 8'd31},
           '{32, 2'b10, 5'd0,  8'd32}, '{63, 2'b10, 5'd31, 8'd63},
           '{64, 2'b11, 5'd0,  8'd64}, '{95, 2'b11, 5'd31, 8'd95}};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; hang = 1'b0;
    start_cnt = 0; start_we_bad = 0; start_cyc = 0; last_we_cyc = 0; err_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'(RST_EXP));
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", 64'(outs()), 64'(RST_EXP));

    // Load mapping: value = index, idle cycle every third byte.
    for (int i = 0; i < 96; i++) job_b[i] = 8'(i);
    wl_sel.delete(); wl_addr.delete(); wl_data.delete();
    start_cnt = 0; start_we_bad = 0;
    send_job(1'b1);
    repeat (3) @(negedge clk);
    chk("we_count", 64'(wl_sel.size()), 64'd96);
    if (wl_sel.size() == 96) begin
      for (int v = 0; v < 6; v++) begin
        chk("wr_sel",  64'(wl_sel[wv[v].idx]),  64'(wv[v].sel));
        chk("wr_addr", 64'(wl_addr[wv[v].idx]), 64'(wv[v].addr));
        chk("wr_data", 64'(wl_data[wv[v].idx]), 64'(wv[v].data));
      end
      bad = 0;
      for (int i = 0; i < 96; i++)
        if (wl_sel[i] != 2'(1 + i / 32) || wl_addr[i] != 5'(i % 32) || wl_data[i] != 8'(i)) bad++;
      chk("wr_all_bytes_bad", 64'(bad), 64'd0);
    end
    chk("start_count", 64'(start_cnt), 64'd1);
    chk("start_with_we", 64'(start_we_bad), 64'd0);
    chk("start_after_last_we", 64'(start_cyc - last_we_cyc), 64'd1);
    recv(32, -1, -1, res, got);
    chk("job1_bytes", 64'(got), 64'd32);
    @(negedge clk);
    chk("job1_idle_busy", 64'(busy), 64'd0);

    // End-to-end: 5^3 mod 0x21 = 0x1A.
    fill_job(64'h5, 64'h3, 64'h21);
    send_job(1'b0);
    recv(32, -1, -1, res, got);
    chk("e2e_bytes", 64'(got), 64'd32);
    check_result("e2e_byte", res, 256'h1A);
    @(negedge clk);
    chk("e2e_busy_done", 64'(busy), 64'd0);
    chk("e2e_in_ready", 64'(in_ready), 64'd1);

    // Backpressure at byte 5 with distinct result bytes (E=1, M<N).
    fill_job(64'h0807060504030201, 64'h1, 64'hFFFFFFFFFFFFFFFF);
    send_job(1'b0);
    recv(32, 5, -1, res, got);
    chk("bp_bytes", 64'(got), 64'd32);
    check_result("bp_byte", res, 256'h0807060504030201);
    @(negedge clk);
    chk("bp_busy_done", 64'(busy), 64'd0);

    // Reset mid-read at byte 10, then a fresh job: 7^2 mod 100 = 0x31.
    send_job(1'b0);
    recv(32, -1, 10, res, got);
    chk("rst_partial_bytes", 64'(got), 64'd10);
    fill_job(64'h7, 64'h2, 64'd100);
    send_job(1'b0);
    recv(32, -1, -1, res, got);
    check_result("post_rst_byte", res, 256'h31);
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Timeout: core never raises ready again.
    hang = 1'b1; err_cnt = 0;
    fill_job(64'h5, 64'h3, 64'h21);
    send_job(1'b0);
    t = 0;
    while (!err_timeout && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_seen", 64'(err_timeout), 64'd1);
    chk("timeout_delay", 64'(cyc - start_cyc), 64'd100);
    chk("timeout_oe_low", 64'(core_oe), 64'd0);
    @(negedge clk);
    chk("timeout_pulse_len", 64'(err_timeout), 64'd0);
    chk("timeout_back_load", 64'(in_ready), 64'd1);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_pulses", 64'(err_cnt), 64'd1);
    reset = 1'b1; hang = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Input held during WAIT_HI is only accepted after RELEASE.
    fill_job(64'h5, 64'h3, 64'h21);
    send_job(1'b0);
    t = 0;
    while (core_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("wait_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = 8'hAB;
    got = 0;
    fork
      recv(32, -1, -1, res, got);
      begin
        t = 0;
        while (!in_ready && t < 1000) begin
          @(negedge clk);
          t++;
        end
        chk("held_byte_after_release", 64'(got), 64'd32);
        wl_sel.delete(); wl_addr.delete(); wl_data.delete();
        @(negedge clk);
        in_valid = 1'b0;
        chk("held_byte_we", 64'(core_we), 64'd1);
        chk("held_byte_bus", 64'({core_reg_sel, core_addr, core_data_w}), 64'({2'b01, 5'd0, 8'hAB}));
        chk("held_byte_busy", 64'(busy), 64'd1);
      end
    join
    check_result("wait_job_byte", res, 256'h1A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
